rggen_bit_field_access_initiator: RTL

- Initiator side of the bit-field access protocol.
- Accepts one host command at a time over a valid/ready request channel.
- Drives the one-cycle bit-field strobe (valid, write, mask, write data) and samples the field's read data.
- Returns a result on a valid/ready response channel.
- Optional write-verify readback detects writes the field did not take: write-once fields already locked, write-only fields, or fields whose value differs from the data written.
- Used as a standalone access engine for bit-field testbenches and for lightweight register blocks without a full bus adapter.

---
 rtl/rggen_bit_field_access_initiator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rggen_bit_field_access_initiator.sv
// Bit-field access initiator: takes one host command, issues a single-cycle
// field strobe (plus an optional readback for writes) and returns the result.
module rggen_bit_field_access_initiator #(
  parameter int WIDTH        = 32,
  parameter bit VERIFY_WRITE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_write,
  input  logic [WIDTH-1:0] i_req_data,
  input  logic [WIDTH-1:0] i_req_mask,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic [1:0]       o_rsp_status,
  output logic             o_bf_valid,
  output logic             o_bf_write,
  output logic [WIDTH-1:0] o_bf_mask,
  output logic [WIDTH-1:0] o_bf_write_data,
  input  logic [WIDTH-1:0] i_bf_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    VERIFY,
    RESP
  } state_e;

  localparam logic [1:0] STATUS_OK         = 2'd0;
  localparam logic [1:0] STATUS_MISMATCH   = 2'd1;
  localparam logic [1:0] STATUS_EMPTY_MASK = 2'd2;

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [WIDTH-1:0] read_masked;
  logic [WIDTH-1:0] write_masked;

  assign read_masked  = i_bf_read_data & mask_q;
  assign write_masked = data_q & mask_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      data_q       <= '0;
      mask_q       <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= STATUS_OK;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    data_d       = data_q;
    mask_d       = mask_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          write_d = i_req_write;
          data_d  = i_req_data;
          mask_d  = i_req_mask;
          // An empty mask touches nothing, so the field is never strobed.
          if (i_req_mask == '0) begin
            rsp_data_d   = '0;
            rsp_status_d = STATUS_EMPTY_MASK;
            state_d      = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rsp_data_d   = read_masked;
          rsp_status_d = STATUS_OK;
          state_d      = RESP;
        end else if (VERIFY_WRITE) begin
          state_d = VERIFY;
        end else begin
          rsp_data_d   = '0;
          rsp_status_d = STATUS_OK;
          state_d      = RESP;
        end
      end
      VERIFY: begin
        // The field committed the write at the previous edge.
        rsp_data_d   = read_masked;
        rsp_status_d = (read_masked != write_masked) ? STATUS_MISMATCH : STATUS_OK;
        state_d      = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobe outputs decode straight from the state so reset kills them at once.
  assign o_req_ready     = (state_q == IDLE);
  assign o_rsp_valid     = (state_q == RESP);
  assign o_rsp_data      = rsp_data_q;
  assign o_rsp_status    = rsp_status_q;
  assign o_bf_valid      = (state_q == ACCESS) || (state_q == VERIFY);
  assign o_bf_write      = (state_q == ACCESS) && write_q;
  assign o_bf_mask       = o_bf_valid ? mask_q : '0;
  assign o_bf_write_data = (state_q == ACCESS) ? write_masked : '0;

endmodule
